// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler
//   Clock-enable generator for the PWM datapath. It divides clk by a
//   divisor that can be changed at runtime, and it applies a new divisor
//   only at terminal count (or on a phase restart) so that no output glitches.
//
//   Parameters
//     DIV_W      width of the divisor and of the internal counter (2..16)
//     DIV_RESET  divisor loaded at reset (1 -> clk/4 square on clk_out)
//
//   Ports
//     clk       in   system clock, rising edge
//     reset     in   asynchronous, active-low reset
//     en        in   count enable; low freezes the counter and outputs
//     sync      in   synchronous phase restart strobe (priority over en)
//     div_val   in   new divisor value
//     div_load  in   strobe that captures div_val into the shadow register
//     tick      out  one-cycle pulse per divided period (registered)
//     clk_out   out  divided square wave, period 2*(div_q+1) (registered)
//     pend      out  high while a loaded divisor waits to be applied
//     phase     out  registered counter copy, 0 while tick is high
//                    (present only with PWM_PRESCALER_PHASE_OUT_EN)
//
//   Optional feature macro: PWM_PRESCALER_PHASE_OUT_EN
// ---------------------------------------------------------------------------
module pwm_prescaler #(
   parameter int unsigned DIV_W     = 8,
   parameter int unsigned DIV_RESET = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sync,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   output logic             tick,
   output logic             clk_out,
`ifdef PWM_PRESCALER_PHASE_OUT_EN
   output logic [DIV_W-1:0] phase,
`endif
   output logic             pend
);

   localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RESET);
   localparam logic [DIV_W-1:0] CNT_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] CNT_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] cnt_q,    cnt_d;
   logic [DIV_W-1:0] div_q,    div_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pend_q,   pend_d;
   logic             tog_q,    tog_d;
   logic             tick_q,   tick_d;
   logic             clk_out_q;
   logic             tc_s;

   // Next-state logic: sync restart beats terminal count, which beats counting.
   always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      tog_d    = tog_q;
      tick_d   = 1'b0;
      // Terminal count only exists on enabled cycles; a frozen counter never
      // reaches it, so a pending divisor waits through the freeze.
      tc_s     = en && (cnt_q == div_q);

      if (sync) begin
         cnt_d = CNT_ZERO;
         tog_d = 1'b0;
         // A load in the same cycle is newer than the shadow and wins.
         if (div_load) begin
            div_d    = div_val;
            shadow_d = div_val;
            pend_d   = 1'b0;
         end else if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
         end else begin
            div_d  = div_q;
            pend_d = 1'b0;
         end
      end else if (tc_s) begin
         cnt_d  = CNT_ZERO;
         tog_d  = ~tog_q;
         tick_d = 1'b1;
         // Period boundary: forward a coincident load directly, otherwise
         // apply whatever the shadow holds.
         if (div_load) begin
            div_d    = div_val;
            shadow_d = div_val;
            pend_d   = 1'b0;
         end else if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
         end else begin
            div_d  = div_q;
            pend_d = 1'b0;
         end
      end else begin
         // cnt_q < div_q here whenever en is high, so the increment cannot wrap.
         if (en) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
         if (div_load) begin
            shadow_d = div_val;
            pend_d   = 1'b1;
         end else begin
            shadow_d = shadow_q;
            pend_d   = pend_q;
         end
      end
   end

   // State and output registers; clk_out is a registered copy of the toggle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= CNT_ZERO;
         div_q     <= DIV_RST_V;
         shadow_q  <= CNT_ZERO;
         pend_q    <= 1'b0;
         tog_q     <= 1'b0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         shadow_q  <= shadow_d;
         pend_q    <= pend_d;
         tog_q     <= tog_d;
         tick_q    <= tick_d;
         clk_out_q <= tog_q;
      end
   end

`ifdef PWM_PRESCALER_PHASE_OUT_EN
   logic [DIV_W-1:0] phase_q;

   // Phase tracks the counter value that accompanies the registered tick,
   // so it reads 0 exactly while tick is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q <= CNT_ZERO;
      end else begin
         phase_q <= cnt_d;
      end
   end

   assign phase = phase_q;
`endif

   assign tick    = tick_q;
   assign clk_out = clk_out_q;
   assign pend    = pend_q;

endmodule

// File: tb/tb_pwm_prescaler.sv
module tb_pwm_prescaler;

   localparam int DIV_W     = 8;
   localparam int DIV_RESET = 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             en = 1'b0;
   logic             sync = 1'b0;
   logic [DIV_W-1:0] div_val = '0;
   logic             div_load = 1'b0;
   logic             tick;
   logic             clk_out;
   logic             pend;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: "cycles left before the terminal-count cycle",
   // the active divisor, shadow/pending, half-period parity and outputs.
   int   m_left, m_div, m_shadow;
   logic m_pend, m_tog, m_tick, m_clk;
   int   cyc;

   pwm_prescaler #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) dut (
      .clk(clk), .reset(reset), .en(en), .sync(sync),
      .div_val(div_val), .div_load(div_load),
      .tick(tick), .clk_out(clk_out), .pend(pend)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_left = DIV_RESET; m_div = DIV_RESET; m_shadow = 0;
      m_pend = 1'b0; m_tog = 1'b0; m_tick = 1'b0; m_clk = 1'b0;
   endtask

   task automatic model_step(input logic e, input logic s, input int dv, input logic dl);
      int   nd;
      logic old_half;
      logic fire;
      old_half = m_tog;
      if (s) begin
         nd = dl ? dv : (m_pend ? m_shadow : m_div);
         if (dl) m_shadow = dv;
         m_div = nd; m_pend = 1'b0; m_left = nd; m_tog = 1'b0; m_tick = 1'b0;
      end else begin
         fire   = e && (m_left == 0);
         m_tick = fire;
         if (fire) begin
            nd = dl ? dv : (m_pend ? m_shadow : m_div);
            if (dl) m_shadow = dv;
            m_div = nd; m_pend = 1'b0; m_left = nd; m_tog = ~m_tog;
         end else begin
            if (e) m_left = m_left - 1;
            if (dl) begin
               m_shadow = dv; m_pend = 1'b1;
            end
         end
      end
      m_clk = old_half;
   endtask

   // Called at a falling edge: apply inputs, advance model, land on next falling edge.
   task automatic drive(input logic e, input logic s, input int dv, input logic dl);
      en = e; sync = s; div_val = dv[DIV_W-1:0]; div_load = dl;
      model_step(e, s, dv, dl);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({tick, clk_out, pend} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_state got t/c/p=%b%b%b want 000", tick, clk_out, pend);
      end
      reset = 1'b1;
   endtask

   task automatic test_default_ratio();
      int first_rise;
      first_rise = -1;
      for (int k = 1; k <= 12; k++) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         n_cmp++;
         if ({tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL default_model k=%0d got t/c/p=%b%b%b want %b%b%b", k, tick, clk_out, pend, m_tick, m_clk, m_pend);
         end
         n_cmp++;
         if (tick !== ((k % 2) == 0)) begin
            n_err++;
            $display("FAIL default_tick k=%0d got %b want %b", k, tick, (k % 2) == 0);
         end
         if (clk_out === 1'b1 && first_rise < 0) first_rise = k;
      end
      n_cmp++;
      if (first_rise != 3) begin
         n_err++;
         $display("FAIL default_first_rise got %0d want 3", first_rise);
      end
   endtask

   task automatic test_load4();
      int last_t, gap;
      last_t = -1; gap = -1;
      drive(1'b1, 1'b0, 4, 1'b1);
      n_cmp++;
      if (pend !== 1'b1) begin
         n_err++;
         $display("FAIL load4_pend got %b want 1", pend);
      end
      for (int k = 0; k < 25; k++) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         n_cmp++;
         if ({tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL load4_model k=%0d got t/c/p=%b%b%b want %b%b%b", k, tick, clk_out, pend, m_tick, m_clk, m_pend);
         end
         if (tick === 1'b1) begin
            if (last_t >= 0) gap = k - last_t;
            last_t = k;
         end
      end
      n_cmp++;
      if (gap != 5 || pend !== 1'b0) begin
         n_err++;
         $display("FAIL load4_spacing got gap=%0d pend=%b want gap=5 pend=0", gap, pend);
      end
   endtask

   task automatic test_div0();
      logic prev_c;
      int   last_t, gap;
      last_t = -1; gap = -1;
      drive(1'b1, 1'b0, 0, 1'b1);
      repeat (6) drive(1'b1, 1'b0, 0, 1'b0);
      prev_c = clk_out;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         n_cmp++;
         if (tick !== 1'b1 || clk_out === prev_c) begin
            n_err++;
            $display("FAIL div0_pattern k=%0d got tick=%b clk_out=%b prev=%b want tick=1 toggling", k, tick, clk_out, prev_c);
         end
         prev_c = clk_out;
      end
      drive(1'b1, 1'b0, 3, 1'b1);
      for (int k = 0; k < 14; k++) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         n_cmp++;
         if ({tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL div0_back_model k=%0d got t/c/p=%b%b%b want %b%b%b", k, tick, clk_out, pend, m_tick, m_clk, m_pend);
         end
         if (tick === 1'b1) begin
            if (last_t >= 0) gap = k - last_t;
            last_t = k;
         end
      end
      n_cmp++;
      if (gap != 4) begin
         n_err++;
         $display("FAIL div0_back_spacing got %0d want 4", gap);
      end
   endtask

   // Bring the model (and DUT) to divisor d with the counter at 0.
   task automatic settle_div(input int d, input string tag);
      int guard;
      guard = 0;
      if (m_div != d) drive(1'b1, 1'b0, d, 1'b1);
      while (!(m_tick && m_div == d && !m_pend) && guard < 40) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         guard++;
      end
      n_cmp++;
      if (guard >= 40 || tick !== 1'b1) begin
         n_err++;
         $display("FAIL %s_settle got tick=%b guard=%0d want tick=1 within 40", tag, tick, guard);
      end
   endtask

   task automatic test_en_freeze();
      logic held_c;
      int   found;
      settle_div(5, "freeze");
      repeat (3) drive(1'b1, 1'b0, 0, 1'b0);
      held_c = clk_out;
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, 1'b0, 0, 1'b0);
         n_cmp++;
         if (tick !== 1'b0 || clk_out !== held_c || {tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL freeze_hold k=%0d got tick=%b clk_out=%b want tick=0 clk_out=%b", k, tick, clk_out, held_c);
         end
      end
      found = -1;
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         n_cmp++;
         if ({tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL freeze_resume_model k=%0d got t/c/p=%b%b%b want %b%b%b", k, tick, clk_out, pend, m_tick, m_clk, m_pend);
         end
         if (tick === 1'b1 && found < 0) found = k;
      end
      n_cmp++;
      if (found != 3) begin
         n_err++;
         $display("FAIL freeze_resume_tick got %0d want 3", found);
      end
   endtask

   task automatic test_sync();
      int found;
      settle_div(5, "sync");
      drive(1'b1, 1'b0, 2, 1'b1);
      drive(1'b1, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 1'b0);
      n_cmp++;
      if (pend !== 1'b1) begin
         n_err++;
         $display("FAIL sync_pre_pend got %b want 1", pend);
      end
      drive(1'b1, 1'b1, 0, 1'b0);
      n_cmp++;
      if (pend !== 1'b0 || tick !== 1'b0) begin
         n_err++;
         $display("FAIL sync_apply got pend=%b tick=%b want 0 0", pend, tick);
      end
      found = -1;
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         if (k == 1) begin
            n_cmp++;
            if (clk_out !== 1'b0) begin
               n_err++;
               $display("FAIL sync_clk_out got %b want 0", clk_out);
            end
         end
         n_cmp++;
         if ({tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL sync_model k=%0d got t/c/p=%b%b%b want %b%b%b", k, tick, clk_out, pend, m_tick, m_clk, m_pend);
         end
         if (tick === 1'b1 && found < 0) found = k;
      end
      n_cmp++;
      if (found != 3) begin
         n_err++;
         $display("FAIL sync_first_tick got %0d want 3", found);
      end
   endtask

   task automatic test_back_to_back();
      settle_div(5, "b2b");
      drive(1'b1, 1'b0, 6, 1'b1);
      drive(1'b1, 1'b0, 2, 1'b1);
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         n_cmp++;
         if ({tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL b2b_model k=%0d got t/c/p=%b%b%b want %b%b%b", k, tick, clk_out, pend, m_tick, m_clk, m_pend);
         end
      end
   endtask

   task automatic test_async_reset();
      int guard;
      guard = 0;
      settle_div(6, "areset");
      drive(1'b1, 1'b0, 3, 1'b1);
      while (!(m_clk && m_pend) && guard < 30) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         if (!m_pend) drive(1'b1, 1'b0, 3, 1'b1);
         guard++;
      end
      n_cmp++;
      if (clk_out !== 1'b1 || pend !== 1'b1) begin
         n_err++;
         $display("FAIL areset_setup got clk_out=%b pend=%b want 1 1", clk_out, pend);
      end
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({tick, clk_out, pend} !== 3'b000) begin
         n_err++;
         $display("FAIL areset_immediate got t/c/p=%b%b%b want 000", tick, clk_out, pend);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 1'b0, 0, 1'b0);
         n_cmp++;
         if (tick !== ((k % 2) == 0) || {tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL areset_resume k=%0d got t/c/p=%b%b%b want %b%b%b", k, tick, clk_out, pend, m_tick, m_clk, m_pend);
         end
      end
   endtask

   task automatic test_random();
      logic e, s, dl;
      int   dv;
      for (int k = 0; k < 1500; k++) begin
         e  = ($urandom_range(0, 9) != 0);
         s  = ($urandom_range(0, 39) == 0);
         dl = ($urandom_range(0, 9) == 0);
         dv = $urandom_range(0, 6);
         drive(e, s, dv, dl);
         n_cmp++;
         if ({tick, clk_out, pend} !== {m_tick, m_clk, m_pend}) begin
            n_err++;
            $display("FAIL random_model k=%0d got t/c/p=%b%b%b want %b%b%b", k, tick, clk_out, pend, m_tick, m_clk, m_pend);
         end
      end
   endtask

   initial begin
      cyc = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_default_ratio();
      test_load4();
      test_div0();
      test_en_freeze();
      test_sync();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
